// File: rtl/ball_pkg.sv
// Shared state encoding and default geometry for the ball axis controllers.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MOVE_POS = 2'd1,
        MOVE_NEG = 2'd2
    } ball_state_t;

    localparam int BALL_POS_MAX   = 1023;
    localparam int BALL_RADIUS    = 10;
    localparam int BALL_START_POS = 300;
    localparam int BALL_TICK_DIV  = 800_000;

endpackage

// File: rtl/ball_tick_gen.sv
// Reloadable down-counter that strobes once every TICK_DIV running cycles.
// Latency: tick is combinational from the count; first tick TICK_DIV run cycles after clear.
// Backpressure: run=0 freezes the count; clear forces a full reload and suppresses tick.
module ball_tick_gen
    import ball_pkg::*;
#(
    parameter int TICK_DIV = BALL_TICK_DIV
) (
    input  logic pclk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && !clear && (cnt == '0);

    // Count down while running; reload on clear or on expiry.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            cnt <= RELOAD;
        end else if (clear || tick) begin
            cnt <= RELOAD;
        end else if (run) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ball_axis_ctrl.sv
// One-axis ball motion controller: serve, move per tick, reflect off walls and objects.
// Latency: pos/dir/pulses register on the tick cycle, TICK_DIV enabled cycles after launch.
// Backpressure: enable=0 pauses motion and counter; collisions keep latching while paused.
module ball_axis_ctrl
    import ball_pkg::*;
#(
    parameter int POS_W     = 12,
    parameter int POS_MIN   = 0,
    parameter int POS_MAX   = BALL_POS_MAX,
    parameter int RADIUS    = BALL_RADIUS,
    parameter int START_POS = BALL_START_POS,
    parameter int TICK_DIV  = BALL_TICK_DIV,
    parameter int SPEED_W   = 3
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               enable,
    input  logic               launch,
    input  logic               launch_dir,
    input  logic               serve,
    input  logic [SPEED_W-1:0] speed,
    input  logic [15:0]        collision_det,
    output logic [POS_W-1:0]   pos,
    output logic               dir,
    output logic               tick,
    output logic               wall_hit,
    output logic               bounce
);

    // One extra bit so pos+speed cannot wrap and pos-speed can go negative.
    localparam int EW = POS_W + 1;
    typedef logic signed [EW-1:0] ext_t;

    localparam ext_t HI = ext_t'(POS_MAX - RADIUS);
    localparam ext_t LO = ext_t'(POS_MIN + RADIUS);
    localparam logic [POS_W-1:0] HI_POS    = POS_W'(POS_MAX - RADIUS);
    localparam logic [POS_W-1:0] LO_POS    = POS_W'(POS_MIN + RADIUS);
    localparam logic [POS_W-1:0] START_VAL = POS_W'(START_POS);

    ball_state_t      state, state_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic             dir_nxt, flag, flag_nxt, wall_nxt, bounce_nxt;
    logic             moving, hit, tick_evt;
    ext_t             pos_ext, spd_ext, c_up, c_dn;

    assign moving  = (state == MOVE_POS) || (state == MOVE_NEG);
    assign hit     = flag || (collision_det != '0);
    assign pos_ext = ext_t'({1'b0, pos});
    assign spd_ext = ext_t'({1'b0, speed});
    assign c_up    = pos_ext + spd_ext;
    assign c_dn    = pos_ext - spd_ext;

    ball_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .pclk  (pclk),
        .reset (reset),
        .run   (enable && moving),
        .clear (serve || !moving),
        .tick  (tick_evt)
    );

    // Next state, position and pulses; walls win over latched collisions.
    always_comb begin
        state_nxt  = state;
        pos_nxt    = pos;
        dir_nxt    = dir;
        flag_nxt   = flag;
        wall_nxt   = 1'b0;
        bounce_nxt = 1'b0;
        if (serve) begin
            state_nxt = IDLE;
            pos_nxt   = START_VAL;
            flag_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state_nxt = launch_dir ? MOVE_POS : MOVE_NEG;
                        dir_nxt   = launch_dir;
                    end
                end
                MOVE_POS, MOVE_NEG: begin
                    flag_nxt = hit;
                    // A zero-speed tick is a no-op and keeps the collision flag.
                    if (tick_evt && (speed != '0)) begin
                        flag_nxt = 1'b0;
                        if (state == MOVE_POS) begin
                            if (c_up >= HI) begin
                                pos_nxt   = HI_POS;
                                state_nxt = MOVE_NEG;
                                dir_nxt   = 1'b0;
                                wall_nxt  = 1'b1;
                            end else if (hit) begin
                                pos_nxt    = (c_dn <= LO) ? LO_POS : c_dn[POS_W-1:0];
                                state_nxt  = MOVE_NEG;
                                dir_nxt    = 1'b0;
                                bounce_nxt = 1'b1;
                            end else begin
                                pos_nxt = c_up[POS_W-1:0];
                            end
                        end else begin
                            if (c_dn <= LO) begin
                                pos_nxt   = LO_POS;
                                state_nxt = MOVE_POS;
                                dir_nxt   = 1'b1;
                                wall_nxt  = 1'b1;
                            end else if (hit) begin
                                pos_nxt    = (c_up >= HI) ? HI_POS : c_up[POS_W-1:0];
                                state_nxt  = MOVE_POS;
                                dir_nxt    = 1'b1;
                                bounce_nxt = 1'b1;
                            end else begin
                                pos_nxt = c_dn[POS_W-1:0];
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, position, direction, collision flag and one-cycle strobes.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pos      <= START_VAL;
            dir      <= 1'b1;
            flag     <= 1'b0;
            tick     <= 1'b0;
            wall_hit <= 1'b0;
            bounce   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            dir      <= dir_nxt;
            flag     <= flag_nxt;
            tick     <= tick_evt;
            wall_hit <= wall_nxt;
            bounce   <= bounce_nxt;
        end
    end

endmodule

// File: doc/ball_axis_ctrl.md
BALL_AXIS_CTRL -- requirements
Module: ball_axis_ctrl

Interface
REQ-001 SHALL have parameter POS_W, default 12, position width in bits.
REQ-002 SHALL have parameter POS_MIN, default 0, lowest screen coordinate on the axis.
REQ-003 SHALL have parameter POS_MAX, default 1023, highest screen coordinate on the axis.
REQ-004 SHALL have parameter RADIUS, default 10, ball radius in pixels.
REQ-005 SHALL have parameter START_POS, default 300, serve/reset position.
REQ-006 SHALL have parameter TICK_DIV, default 800_000, pclk cycles per motion tick (minimum 2).
REQ-007 SHALL have parameter SPEED_W, default 3, speed field width.
REQ-008 SHALL use one clock and an asynchronous, active-low reset.
REQ-009 SHALL have pclk  input  1  pixel clock; all state on rising edge.
REQ-010 SHALL have reset  input  1  asynchronous active-low reset.
REQ-011 SHALL have enable  input  1  1 = run, 0 = pause.
REQ-012 SHALL have launch  input  1  single-cycle serve pulse.
REQ-013 SHALL have launch_dir  input  1  0 = negative, 1 = positive.
REQ-014 SHALL have serve  input  1  synchronous return to the idle state.
REQ-015 SHALL have speed  input  SPEED_W  pixels moved per tick.
REQ-016 SHALL have collision_det  input  16  any nonzero bit = object hit.
REQ-017 SHALL have pos  output  POS_W  ball centre coordinate.
REQ-018 SHALL have dir  output  1  current direction, 1 = positive.
REQ-019 SHALL have tick  output  1  one-cycle strobe on each motion update.
REQ-020 SHALL have wall_hit  output  1  one-cycle pulse on a wall reflection.
REQ-021 SHALL have bounce  output  1  one-cycle pulse on an object reflection.

Function
REQ-022 SHALL implement states IDLE, MOVE_POS and MOVE_NEG.
REQ-023 SHALL, in IDLE, hold pos = START_POS and the tick counter at TICK_DIV-1, and collisions SHALL NOT be latched.
REQ-024 SHALL, on launch in IDLE, enter MOVE_POS or MOVE_NEG per launch_dir on the next cycle; launch outside IDLE is ignored.
REQ-025 SHALL, in MOVE states with enable=1, decrement the counter each cycle; at 0 it reloads TICK_DIV-1 and the cycle is a tick.
REQ-026 SHALL assert the tick output in the cycle pos updates, so pos is updated TICK_DIV cycles after launch.
REQ-027 SHALL, with enable=0, freeze counter, pos and state, while collisions still latch.
REQ-028 SHALL OR a nonzero collision_det in any MOVE-state cycle into a sticky flag, which is cleared at every tick.
REQ-029 SHALL use limits HI = POS_MAX-RADIUS and LO = POS_MIN+RADIUS, with all arithmetic at POS_W+1 bits so no wrap occurs.
REQ-030 SHALL, at a MOVE_POS tick, compute c = pos+speed; if c >= HI then pos=HI, flip to MOVE_NEG and pulse wall_hit.
REQ-031 SHALL, at a MOVE_NEG tick, compute c = pos-speed (signed); if c <= LO then pos=LO, flip to MOVE_POS and pulse wall_hit.
REQ-032 SHALL otherwise, if the flag is set, flip direction, move pos by speed in the new direction (clamped to HI/LO) and pulse bounce.
REQ-033 SHALL otherwise set pos = c.
REQ-034 SHALL give wall priority when a wall and a collision coincide: single reversal, bounce=0, flag cleared.
REQ-035 SHALL, with speed=0 at a tick, leave pos and dir unchanged, assert no pulses and retain the flag.
REQ-036 SHALL, on serve in any state, force IDLE, pos=START_POS and clear the flag next cycle; serve overrides a simultaneous launch.
REQ-037 SHALL set dir = 1 in MOVE_POS, 0 in MOVE_NEG, and hold its last value in IDLE.

Reset
REQ-038 SHALL, while reset=0, immediately force: state IDLE, pos=START_POS, dir=1, counter=TICK_DIV-1, flag=0, tick/wall_hit/bounce=0.
REQ-039 SHALL resume from IDLE after reset deasserts mid-operation; a launch is required to restart.

Structure
REQ-040 SHALL take state encodings and default geometry constants (1023, 10, 300, 800_000) from shared package ball_pkg.
REQ-041 SHALL instantiate the reloadable down-counter as sub-module ball_tick_gen (inputs run and clear; output tick).
REQ-042 SHALL be parametrisable so that one instance per axis (X, Y) covers both axes.

Verification (TICK_DIV=4)
REQ-043 SHALL verify: reset pulse -> pos=300, dir=1, pulses 0, and pos stays 300 for 20 cycles without launch.
REQ-044 SHALL verify: launch with launch_dir=1, speed=1 -> pos=301 with tick=1 in the 4th cycle after MOVE_POS entry, and 302 four cycles later.
REQ-045 SHALL verify: MOVE_POS at pos 1011, speed 3 -> pos 1013, dir 0, wall_hit for one cycle; the next tick gives 1010.
REQ-046 SHALL verify: MOVE_POS at 500, speed 2, collision pulse mid-interval -> next tick pos 498, dir 0, bounce=1 for one cycle.
REQ-047 SHALL verify: MOVE_POS at 1012, speed 2, collision latched -> pos 1013, dir 0, wall_hit=1, bounce=0, and the following tick gives 1011.
REQ-048 SHALL verify: enable=0 for 10 cycles -> pos and counter frozen; reset low mid-interval -> pos=300 asynchronously, then IDLE.
